// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared constants and state type for the fetch-PC sequencer
package fetch_pc_ctrl_pkg;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_GROUP_BYTES = 32'd8;
    typedef enum logic {RUN, DS_FETCH} fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl_next_pc_sel.sv
// next_pc_sel: priority mux for next fetch PC, rescue target, state and flush
module next_pc_sel
    import fetch_pc_ctrl_pkg::*;
(
    input  fetch_state_t state,
    input  logic [31:0]  pc,
    input  logic [31:0]  tgt,
    input  logic         fire,
    input  logic         backend_redirect,
    input  logic [31:0]  backend_pc,
    input  logic         if3_redirect,
    input  logic [31:0]  if3_pc,
    input  logic         if3_rescue_ds,
    input  logic [31:0]  if3_ds_pc,
    input  logic         nlp_taken,
    input  logic [31:0]  nlp_target,
    output logic [31:0]  pc_nxt,
    output logic [31:0]  tgt_nxt,
    output fetch_state_t state_nxt,
    output logic         flush,
    output logic         be_inc,
    output logic         if3_inc
);
    logic        ds;
    logic        rescue;
    logic [31:0] seq;
    always_comb begin
        ds        = state == DS_FETCH;
        be_inc    = backend_redirect;
        // IF3 redirects seen during the rescue are stale; their groups were already flushed
        if3_inc   = !ds && if3_redirect && !backend_redirect;
        rescue    = if3_inc && if3_rescue_ds;
        flush     = be_inc || if3_inc;
        seq       = pc + (pc[2] ? 32'd4 : FETCH_GROUP_BYTES);
        pc_nxt    = be_inc ? backend_pc :
                    if3_inc ? (if3_rescue_ds ? if3_ds_pc : if3_pc) :
                    !fire ? pc :
                    ds ? tgt :
                    nlp_taken ? nlp_target : seq;
        tgt_nxt   = rescue ? if3_pc : tgt;
        state_nxt = be_inc ? RUN :
                    rescue ? DS_FETCH :
                    (ds && fire) ? RUN : state;
    end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: front-end fetch-PC sequencer with delay-slot rescue and redirect counters
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_pc_ctrl_pkg::RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             backend_redirect,
    input  logic [31:0]      backend_pc,
    input  logic             if3_redirect,
    input  logic [31:0]      if3_pc,
    input  logic             if3_rescue_ds,
    input  logic [31:0]      if3_ds_pc,
    input  logic             nlp_taken,
    input  logic [31:0]      nlp_target,
    input  logic             icache_ready,
    output logic             icache_req,
    output logic [31:0]      icache_pc,
    output logic             fetch_single,
    output logic             flush_if12,
    output logic             in_ds_fetch,
    output logic [CNT_W-1:0] perf_if3_redir,
    output logic [CNT_W-1:0] perf_be_redir
);
    fetch_state_t state, state_nxt;
    logic [31:0]  pc_reg, tgt_reg, pc_nxt, tgt_nxt;
    logic         flush, be_inc, if3_inc;
    assign icache_req   = rst && !stall;
    assign icache_pc    = {pc_reg[31:2], 2'b00};
    assign fetch_single = rst && (state == DS_FETCH || pc_reg[2]);
    assign flush_if12   = rst && flush;
    assign in_ds_fetch  = state == DS_FETCH;
    next_pc_sel u_sel (
        .state            (state),
        .pc               (pc_reg),
        .tgt              (tgt_reg),
        .fire             (icache_req && icache_ready),
        .backend_redirect (backend_redirect),
        .backend_pc       (backend_pc),
        .if3_redirect     (if3_redirect),
        .if3_pc           (if3_pc),
        .if3_rescue_ds    (if3_rescue_ds),
        .if3_ds_pc        (if3_ds_pc),
        .nlp_taken        (nlp_taken),
        .nlp_target       (nlp_target),
        .pc_nxt           (pc_nxt),
        .tgt_nxt          (tgt_nxt),
        .state_nxt        (state_nxt),
        .flush            (flush),
        .be_inc           (be_inc),
        .if3_inc          (if3_inc)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg         <= RESET_PC;
            tgt_reg        <= '0;
            state          <= RUN;
            perf_if3_redir <= '0;
            perf_be_redir  <= '0;
        end else begin
            pc_reg         <= pc_nxt;
            tgt_reg        <= tgt_nxt;
            state          <= state_nxt;
            perf_if3_redir <= perf_if3_redir + CNT_W'(if3_inc);
            perf_be_redir  <= perf_be_redir + CNT_W'(be_inc);
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed scenario bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic        stall = 0, backend_redirect = 0, if3_redirect = 0, if3_rescue_ds = 0;
    logic        nlp_taken = 0, icache_ready = 1;
    logic [31:0] backend_pc = 0, if3_pc = 0, if3_ds_pc = 0, nlp_target = 0;
    logic        icache_req, fetch_single, flush_if12, in_ds_fetch;
    logic [31:0] icache_pc, perf_if3_redir, perf_be_redir;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .backend_redirect(backend_redirect), .backend_pc(backend_pc),
        .if3_redirect(if3_redirect), .if3_pc(if3_pc),
        .if3_rescue_ds(if3_rescue_ds), .if3_ds_pc(if3_ds_pc),
        .nlp_taken(nlp_taken), .nlp_target(nlp_target),
        .icache_ready(icache_ready), .icache_req(icache_req), .icache_pc(icache_pc),
        .fetch_single(fetch_single), .flush_if12(flush_if12), .in_ds_fetch(in_ds_fetch),
        .perf_if3_redir(perf_if3_redir), .perf_be_redir(perf_be_redir)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 0;
        #2;
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", icache_req); end
        checks++; if (icache_pc !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc got %h exp BFC00000", icache_pc); end
        checks++; if ({flush_if12, fetch_single, in_ds_fetch} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {flush_if12, fetch_single, in_ds_fetch}); end
        checks++; if (perf_be_redir !== 0 || perf_if3_redir !== 0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_be_redir, perf_if3_redir); end
        step();
        rst = 1;
        #1;
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'hBFC00000) begin errors++; $display("FAIL rel_pc got %b %h exp 1 BFC00000", icache_req, icache_pc); end
        step();
        checks++; if (icache_pc !== 32'hBFC00008 || fetch_single !== 1'b0) begin errors++; $display("FAIL seq1 got %h %b exp BFC00008 0", icache_pc, fetch_single); end
        step();
        checks++; if (icache_pc !== 32'hBFC00010 || fetch_single !== 1'b0) begin errors++; $display("FAIL seq2 got %h %b exp BFC00010 0", icache_pc, fetch_single); end
    endtask

    task automatic test_single();
        backend_redirect = 1; backend_pc = 32'hBFC00004;
        #1;
        checks++; if (flush_if12 !== 1'b1) begin errors++; $display("FAIL be_flush got %b exp 1", flush_if12); end
        step();
        backend_redirect = 0;
        checks++; if (icache_pc !== 32'hBFC00004 || fetch_single !== 1'b1) begin errors++; $display("FAIL single got %h %b exp BFC00004 1", icache_pc, fetch_single); end
        checks++; if (perf_be_redir !== 1) begin errors++; $display("FAIL be_cnt1 got %0d exp 1", perf_be_redir); end
        step();
        checks++; if (icache_pc !== 32'hBFC00008 || fetch_single !== 1'b0) begin errors++; $display("FAIL single_next got %h %b exp BFC00008 0", icache_pc, fetch_single); end
        step();
    endtask

    task automatic test_nlp();
        icache_ready = 0; nlp_taken = 1; nlp_target = 32'h80001000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (icache_pc !== 32'hBFC00010) begin errors++; $display("FAIL nlp_hold%0d got %h exp BFC00010", i, icache_pc); end
        end
        icache_ready = 1;
        step();
        nlp_taken = 0;
        checks++; if (icache_pc !== 32'h80001000) begin errors++; $display("FAIL nlp_take got %h exp 80001000", icache_pc); end
        checks++; if (flush_if12 !== 1'b0) begin errors++; $display("FAIL nlp_noflush got %b exp 0", flush_if12); end
    endtask

    task automatic test_rescue();
        stall = 1;
        if3_redirect = 1; if3_rescue_ds = 1; if3_ds_pc = 32'hBFC00018; if3_pc = 32'h80002000;
        #1;
        checks++; if (flush_if12 !== 1'b1) begin errors++; $display("FAIL rescue_flush got %b exp 1", flush_if12); end
        step();
        if3_redirect = 0; if3_rescue_ds = 0;
        checks++; if (perf_if3_redir !== 1) begin errors++; $display("FAIL if3_cnt1 got %0d exp 1", perf_if3_redir); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (icache_pc !== 32'hBFC00018 || fetch_single !== 1'b1 || in_ds_fetch !== 1'b1 || icache_req !== 1'b0) begin
                errors++; $display("FAIL ds_hold%0d got %h %b %b %b exp BFC00018 1 1 0", i, icache_pc, fetch_single, in_ds_fetch, icache_req);
            end
            if (i < 2) step();
        end
        stall = 0;
        #1;
        checks++; if (flush_if12 !== 1'b0 || icache_req !== 1'b1) begin errors++; $display("FAIL ds_fire got flush %b req %b exp 0 1", flush_if12, icache_req); end
        step();
        checks++; if (icache_pc !== 32'h80002000 || in_ds_fetch !== 1'b0) begin errors++; $display("FAIL ds_target got %h %b exp 80002000 0", icache_pc, in_ds_fetch); end
    endtask

    task automatic test_ds_backend();
        if3_redirect = 1; if3_rescue_ds = 1; if3_ds_pc = 32'h80002008; if3_pc = 32'h90000000;
        step();
        checks++; if (in_ds_fetch !== 1'b1 || icache_pc !== 32'h80002008) begin errors++; $display("FAIL ds2_enter got %b %h exp 1 80002008", in_ds_fetch, icache_pc); end
        if3_pc = 32'h70000000; if3_rescue_ds = 0;
        backend_redirect = 1; backend_pc = 32'h80000180;
        #1;
        checks++; if (flush_if12 !== 1'b1) begin errors++; $display("FAIL ds2_flush got %b exp 1", flush_if12); end
        step();
        backend_redirect = 0; if3_redirect = 0;
        checks++; if (icache_pc !== 32'h80000180 || in_ds_fetch !== 1'b0) begin errors++; $display("FAIL ds2_abort got %h %b exp 80000180 0", icache_pc, in_ds_fetch); end
        checks++; if (perf_be_redir !== 2 || perf_if3_redir !== 2) begin errors++; $display("FAIL ds2_cnt got %0d/%0d exp 2/2", perf_be_redir, perf_if3_redir); end
    endtask

    task automatic test_both();
        backend_redirect = 1; backend_pc = 32'h80000200;
        if3_redirect = 1; if3_pc = 32'h80003000;
        #1;
        checks++; if (flush_if12 !== 1'b1) begin errors++; $display("FAIL both_flush got %b exp 1", flush_if12); end
        step();
        backend_redirect = 0; if3_redirect = 0;
        checks++; if (icache_pc !== 32'h80000200) begin errors++; $display("FAIL both_pc got %h exp 80000200", icache_pc); end
        checks++; if (perf_be_redir !== 3 || perf_if3_redir !== 2) begin errors++; $display("FAIL both_cnt got %0d/%0d exp 3/2", perf_be_redir, perf_if3_redir); end
    endtask

    task automatic test_async_reset();
        if3_redirect = 1; if3_rescue_ds = 1; if3_ds_pc = 32'h80000208; if3_pc = 32'h80004000;
        step();
        if3_redirect = 0; if3_rescue_ds = 0;
        checks++; if (in_ds_fetch !== 1'b1) begin errors++; $display("FAIL ar_enter got %b exp 1", in_ds_fetch); end
        #2 rst = 0;
        #1;
        checks++; if (icache_pc !== 32'hBFC00000 || in_ds_fetch !== 1'b0 || icache_req !== 1'b0 || fetch_single !== 1'b0) begin
            errors++; $display("FAIL ar_now got %h %b %b %b exp BFC00000 0 0 0", icache_pc, in_ds_fetch, icache_req, fetch_single);
        end
        checks++; if (perf_be_redir !== 0 || perf_if3_redir !== 0) begin errors++; $display("FAIL ar_perf got %0d/%0d exp 0/0", perf_be_redir, perf_if3_redir); end
        step();
        rst = 1;
        step();
        checks++; if (icache_pc !== 32'hBFC00008 || in_ds_fetch !== 1'b0) begin errors++; $display("FAIL ar_after got %h %b exp BFC00008 0", icache_pc, in_ds_fetch); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nlp();
        test_rescue();
        test_ds_backend();
        test_both();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Front-end fetch-PC sequencer. Each cycle it decides which PC to present to IF1/I-cache, choosing among four sources in priority order: backend flush, IF3 predecode redirect, NLP taken prediction, sequential. It owns the delay-slot rescue sequence requested by IF3 when the redirecting branch sits in slot 1. It kills IF1/IF2 in-flight groups on every redirect.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.
CNT_W, 32, width of redirect performance counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
stall  in  1  backend/IF-queue full; hold current PC, no new fetch accepted
backend_redirect  in  1  mispredict/exception flush from commit/execute
backend_pc  in  32  target of backend_redirect
if3_redirect  in  1  IF3 predecode redirect (IF3 flushReq)
if3_pc  in  32  IF3 redirect target
if3_rescue_ds  in  1  redirecting branch is slot 1; delay slot not yet fetched
if3_ds_pc  in  32  delay-slot PC (branch PC + 4)
nlp_taken  in  1  NLP hit and taken for current icache_pc (same cycle)
nlp_target  in  32  NLP target
icache_ready  in  1  I-cache accepts request this cycle
icache_req  out  1  fetch request valid
icache_pc  out  32  fetch PC, 4-byte aligned
fetch_single  out  1  only slot 0 of this group is valid
flush_if12  out  1  kill IF1/IF2 pipeline registers
in_ds_fetch  out  1  FSM in DS_FETCH (debug/IF2 tagging)
perf_if3_redir  out  CNT_W  count of accepted IF3 redirects, wraps
perf_be_redir  out  CNT_W  count of backend redirects, wraps

Behaviour:
- Reset (rst=0, async): pc_reg=RESET_PC, tgt_reg=0, state=RUN, counters=0. icache_req=0, flush_if12=0, fetch_single=0, in_ds_fetch=0 while reset is asserted.
- fire = icache_req & icache_ready. icache_req = !stall (rst released). icache_pc = pc_reg.
- fetch_single = (state==DS_FETCH) | pc_reg[2].
- Sequential next PC: pc_reg[2] ? pc_reg+4 : pc_reg+8. 32-bit wrap, no overflow detection.
- FSM states: RUN, DS_FETCH.
- RUN, per-cycle priority:
  1. backend_redirect: pc_reg<=backend_pc; flush_if12=1; perf_be_redir++.
  2. if3_redirect & !if3_rescue_ds: pc_reg<=if3_pc; flush_if12=1; perf_if3_redir++.
  3. if3_redirect & if3_rescue_ds: pc_reg<=if3_ds_pc; tgt_reg<=if3_pc; state<=DS_FETCH; flush_if12=1; perf_if3_redir++.
  4. fire & nlp_taken: pc_reg<=nlp_target.
  5. fire: pc_reg<=sequential next.
  6. Otherwise (stall or !icache_ready): hold.
- Redirects (items 1-3) apply regardless of stall/icache_ready. Latency: the new PC appears on icache_pc the next cycle. The pending unaccepted request is dropped.
- DS_FETCH:
  - nlp_taken is ignored.
  - if3_redirect is ignored (stale; older groups already flushed).
  - backend_redirect: pc_reg<=backend_pc; state<=RUN; flush_if12=1; counter++. This aborts the rescue.
  - fire: pc_reg<=tgt_reg; state<=RUN; flush_if12=0. The delay-slot group must survive.
  - stall: hold pc_reg, tgt_reg, and state.
- flush_if12 is combinational, same cycle as the redirect input.
- Backend and IF3 redirect in the same cycle: backend wins; the IF3 counter is not incremented.
- Async reset mid-DS_FETCH returns to RUN at RESET_PC and discards tgt_reg.

Decomposition:
- Shared package (defs): RESET_PC constant, FETCH_GROUP_BYTES=8, fetch_state_t enum {RUN, DS_FETCH}.
- Sub-module next_pc_sel: purely combinational priority mux computing next pc_reg, next state and flush. The top keeps the registers and counters.

Test Plan:
- Reset release, icache_ready=1, no predictions: icache_pc sequence BFC00000, BFC00008, BFC00010; fetch_single=0.
- pc=BFC00004 after redirect: fetch_single=1; next PC BFC00008.
- nlp_taken target 80001000 at pc BFC00010 with icache_ready=0 for 2 cycles: PC holds; on fire, next icache_pc=80001000.
- if3_redirect, rescue_ds=1, ds_pc=BFC00018, target 80002000, stall=1 for 3 cycles: icache_pc=BFC00018, fetch_single=1 held. After the stall releases and fire: icache_pc=80002000, state RUN, flush_if12=0 on that fire.
- DS_FETCH plus backend_redirect 80000180 in the same cycle: icache_pc=80000180 next cycle, state RUN, perf_be_redir=1.
- backend_redirect and if3_redirect asserted together: backend_pc selected, flush_if12=1, perf_if3_redir unchanged. Async reset asserted mid-cycle: outputs go to reset values immediately.
